key_debouncer_multi: RTL and testbench

Parametrised N-channel push-button conditioner for the lab-board key inputs. Each channel synchronises a raw mechanical key, filters bounce with a restartable stability counter, and emits a debounced level plus single-cycle press, release, long-press and auto-repeat pulses. Consumers are downstream counters and FSMs that need clean one-shot events instead of a raw level.

---
 rtl/key_debouncer_multi.sv | 133 +++++++++++++
 tb/tb_key_debouncer_multi.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_debouncer_multi.sv
// Purpose: N-channel key synchroniser and bounce filter with press, release, long-press and auto-repeat pulses.
// Latency: a raw change first sampled on edge k reaches keyout on edge k+STABLE+1; the pulses are registered with it.
// Backpressure: none. Every pulse is one cycle wide, so consumers must sample every cycle.
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   key[N]     raw asynchronous key inputs (pressed level set by ACTIVE_LOW)
//   keyout[N]  debounced level, 1 = pressed
//   press_p[N], release_p[N]  one-cycle pulses on keyout 0->1 and 1->0
//   long_p[N]  one-cycle pulse once a press has lasted HOLD cycles
//   rep_p[N]   one-cycle pulse every REPEAT cycles after long_p while held (never when REPEAT == 0)
module key_debouncer_multi #(
    parameter int N          = 4,
    parameter int STABLE     = 5,
    parameter int HOLD       = 1000,
    parameter int REPEAT     = 200,
    parameter int ACTIVE_LOW = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] key,
    output logic [N-1:0] keyout,
    output logic [N-1:0] press_p,
    output logic [N-1:0] release_p,
    output logic [N-1:0] long_p,
    output logic [N-1:0] rep_p
);

    localparam int CW = $clog2(STABLE);
    localparam int HW = $clog2(HOLD + REPEAT) + 1;

    localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE - 1);
    localparam logic [HW-1:0] HOLD_M1   = HW'(HOLD - 1);
    localparam logic [HW-1:0] HOLD_V    = HW'(HOLD);
    localparam logic [HW-1:0] RELOAD_AT = HW'(HOLD + REPEAT - 1);

    // Raw level of a released key; also the synchroniser reset value.
    localparam logic RAW_IDLE = (ACTIVE_LOW != 0);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
    localparam logic [1:0] ST_LONG    = 2'd2;

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic          s1_q;
        logic          s2_q;
        logic          kout_q;
        logic          press_q;
        logic          rel_q;
        logic          long_q;
        logic          rep_q;
        logic [CW-1:0] cnt_q;
        logic [HW-1:0] hcnt_q;
        logic [1:0]    st_q;
        logic          p;
        logic          accept;

        // Synchronised sample normalised so that 1 always means pressed.
        assign p      = s2_q ^ RAW_IDLE;
        // The new level has been seen for STABLE consecutive cycles.
        assign accept = (p != kout_q) && (cnt_q == CNT_MAX);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_q    <= RAW_IDLE;
                s2_q    <= RAW_IDLE;
                kout_q  <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                long_q  <= 1'b0;
                rep_q   <= 1'b0;
                cnt_q   <= '0;
                hcnt_q  <= '0;
                st_q    <= ST_IDLE;
            end else begin
                s1_q    <= key[i];
                s2_q    <= s1_q;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                long_q  <= 1'b0;
                rep_q   <= 1'b0;

                // Any sample matching the current level restarts the filter.
                if ((p == kout_q) || (cnt_q == CNT_MAX)) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end

                if (accept) begin
                    // Level change takes priority over hold events, so a
                    // release on the long/repeat edge yields release_p only.
                    kout_q  <= p;
                    press_q <= p;
                    rel_q   <= ~p;
                    hcnt_q  <= '0;
                    st_q    <= p ? ST_PRESSED : ST_IDLE;
                end else if (kout_q) begin
                    case (st_q)
                        ST_PRESSED: begin
                            hcnt_q <= hcnt_q + HW'(1);
                            if (hcnt_q == HOLD_M1) begin
                                st_q   <= ST_LONG;
                                long_q <= 1'b1;
                            end
                        end
                        ST_LONG: begin
                            // hcnt cycles through HOLD..HOLD+REPEAT-1; with
                            // repeat disabled it simply parks at HOLD.
                            if (REPEAT != 0) begin
                                if (hcnt_q == RELOAD_AT) begin
                                    hcnt_q <= HOLD_V;
                                    rep_q  <= 1'b1;
                                end else begin
                                    hcnt_q <= hcnt_q + HW'(1);
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end

        assign keyout[i]    = kout_q;
        assign press_p[i]   = press_q;
        assign release_p[i] = rel_q;
        assign long_p[i]    = long_q;
        assign rep_p[i]     = rep_q;
    end

endmodule

// File: tb/tb_key_debouncer_multi.sv
// Purpose: randomized and directed bench for key_debouncer_multi with an event scoreboard.
// Latency: expected events are queued on the clock edge that produces them and popped at the next falling edge.
// Backpressure: none; the monitor observes every cycle.
module tb_key_debouncer_multi;

    localparam int N      = 4;
    localparam int STABLE = 5;
    localparam int HOLD   = 20;
    localparam int REPEAT = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] key;
    logic [N-1:0] keyout, press_p, release_p, long_p, rep_p;
    logic         k2_keyout, k2_press, k2_rel, k2_long, k2_rep;

    always #5 clk = ~clk;

    key_debouncer_multi #(
        .N(N), .STABLE(STABLE), .HOLD(HOLD), .REPEAT(REPEAT), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key(key),
        .keyout(keyout), .press_p(press_p), .release_p(release_p),
        .long_p(long_p), .rep_p(rep_p)
    );

    // Single channel with repeat disabled, fed from channel 0.
    key_debouncer_multi #(
        .N(1), .STABLE(STABLE), .HOLD(HOLD), .REPEAT(0), .ACTIVE_LOW(1)
    ) u_norep (
        .clk(clk), .rst_n(rst_n), .key(key[0]),
        .keyout(k2_keyout), .press_p(k2_press), .release_p(k2_rel),
        .long_p(k2_long), .rep_p(k2_rep)
    );

    typedef struct {
        int           e;
        logic [N-1:0] pr;
        logic [N-1:0] rl;
        logic [N-1:0] lg;
        logic [N-1:0] rp;
    } ev_t;

    ev_t          sbq[$];
    logic         ph [N][64];   // pressed-sense raw sample history, indexed by edge number
    logic [N-1:0] mlvl;
    int           press_e [N];
    int           ecount;
    logic         x_pr0, x_rl0, x_lg0;
    int           checks;
    int           errors;
    int           dur [N];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecount);
        end
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < N; ch++) begin
            for (int j = 0; j < 64; j++) ph[ch][j] = 1'b0;
            press_e[ch] = 0;
        end
        mlvl  = '0;
        x_pr0 = 1'b0;
        x_rl0 = 1'b0;
        x_lg0 = 1'b0;
        sbq.delete();
    endtask

    // Level flips once the last STABLE synchronised samples (raw key two
    // edges old) all disagree with it; hold events follow from the
    // distance in edges to the press.
    task automatic model_step();
        ev_t ev;
        bit  flip_ok;
        int  d;
        ecount++;
        ev.e  = ecount;
        ev.pr = '0;
        ev.rl = '0;
        ev.lg = '0;
        ev.rp = '0;
        for (int ch = 0; ch < N; ch++) begin
            flip_ok = 1'b1;
            for (int j = 1; j <= STABLE; j++)
                if (ph[ch][(ecount - 1 - j) & 63] == mlvl[ch]) flip_ok = 1'b0;
            if (flip_ok) begin
                if (!mlvl[ch]) begin
                    ev.pr[ch]   = 1'b1;
                    press_e[ch] = ecount;
                end else begin
                    ev.rl[ch] = 1'b1;
                end
                mlvl[ch] = ~mlvl[ch];
            end else if (mlvl[ch]) begin
                d = ecount - press_e[ch];
                if (d == HOLD) ev.lg[ch] = 1'b1;
                if (REPEAT > 0 && d > HOLD && ((d - HOLD) % REPEAT) == 0) ev.rp[ch] = 1'b1;
            end
            ph[ch][ecount & 63] = ~key[ch];
        end
        x_pr0 = ev.pr[0];
        x_rl0 = ev.rl[0];
        x_lg0 = ev.lg[0];
        if (|{ev.pr, ev.rl, ev.lg, ev.rp}) sbq.push_back(ev);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Monitor: compares levels every cycle and pops the scoreboard whenever
    // the DUT presents a pulse (or an expected pulse is overdue).
    initial begin
        ev_t h;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset_outputs", 32'({keyout, press_p, release_p, long_p, rep_p}), 32'd0);
                chk("reset_outputs_norep", 32'({k2_keyout, k2_press, k2_rel, k2_long, k2_rep}), 32'd0);
            end else begin
                chk("keyout_level", 32'(keyout), 32'(mlvl));
                chk("norep_level", 32'(k2_keyout), 32'(mlvl[0]));
                chk("norep_press", 32'(k2_press), 32'(x_pr0));
                chk("norep_release", 32'(k2_rel), 32'(x_rl0));
                chk("norep_long", 32'(k2_long), 32'(x_lg0));
                chk("norep_no_repeat", 32'(k2_rep), 32'd0);
                if (|{press_p, release_p, long_p, rep_p}) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_event", 32'({press_p, release_p, long_p, rep_p}), 32'd0);
                    end else begin
                        h = sbq.pop_front();
                        chk("event_edge", 32'(ecount), 32'(h.e));
                        chk("press_p", 32'(press_p), 32'(h.pr));
                        chk("release_p", 32'(release_p), 32'(h.rl));
                        chk("long_p", 32'(long_p), 32'(h.lg));
                        chk("rep_p", 32'(rep_p), 32'(h.rp));
                    end
                end else if (sbq.size() > 0 && sbq[0].e <= ecount) begin
                    h = sbq.pop_front();
                    chk("missing_event", 32'({press_p, release_p, long_p, rep_p}),
                        32'({h.pr, h.rl, h.lg, h.rp}));
                end
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        logic [5:0] bounce;
        checks = 0;
        errors = 0;
        ecount = 0;
        for (int ch = 0; ch < N; ch++) dur[ch] = 0;
        bounce = 6'b100101;             // applied LSB first: 1,0,1,0,0,1

        // Reset with channel 0 held pressed through deassertion.
        key   = 4'b1110;
        rst_n = 1'b0;
        tick(4);
        rst_n = 1'b1;

        // Channel 1 bounce, short hold, release; channel 0 long press with repeats.
        tick(5);
        for (int i = 0; i < 6; i++) begin
            key[1] = bounce[i];
            tick(1);
        end
        key[1] = 1'b0;
        tick(15);
        key[1] = 1'b1;
        tick(25);
        key[0] = 1'b1;
        tick(30);

        // Release lands exactly on the long-press edge.
        key[2] = 1'b0;
        tick(HOLD);
        key[2] = 1'b1;
        tick(30);

        // Channels 0 and 3 together while channel 2 bounces.
        key[0] = 1'b0;
        key[3] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            key[2] = 1'($urandom_range(0, 1));
            tick(1);
        end
        key[2] = 1'b0;
        tick(60);
        key = '1;
        tick(30);

        // Asynchronous reset in the LONG state, key kept held.
        key[0] = 1'b0;
        tick(35);
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(40);
        key[0] = 1'b1;
        tick(20);

        // Random phase: mix of bounces and long holds on every channel.
        for (int c = 0; c < 3000; c++) begin
            for (int ch = 0; ch < N; ch++) begin
                if (dur[ch] == 0) begin
                    key[ch] = ~key[ch];
                    dur[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6))
                                                          : int'($urandom_range(8, 70));
                end else begin
                    dur[ch] = dur[ch] - 1;
                end
            end
            tick(1);
        end
        key = '1;
        tick(40);

        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
